axil_protocol_monitor: RTL and testbench
========================================

AXIL_PROTOCOL_MONITOR -- requirements
Module: axil_protocol_monitor

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width, a power of two, at least 16.
REQ-003 Parameter ERR_RESP_EN, default 1'b1: enables all checks.
REQ-004 Parameter TIMEOUT_CYCLES, default 256: stall limit (cycles), minimum 2.
REQ-005 Parameter CNT_WIDTH, default 16: error counter width.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 s_axi_awaddr/awprot/awvalid/awready  in  ADDR_WIDTH/3/1/1  AW channel, observed only.
REQ-009 s_axi_wdata/wstrb/wvalid/wready  in  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel, observed only.
REQ-010 s_axi_araddr/arprot/arvalid/arready  in  ADDR_WIDTH/3/1/1  AR channel, observed only.
REQ-011 clr_i  in  1  synchronous clear of sticky status and counter.
REQ-012 err_awrite_o/err_write_o/err_read_o  out  1 each  combinational per-cycle channel error.
REQ-013 err_status_o  out  7  sticky error bits; see REQ-017.
REQ-014 err_count_o  out  CNT_WIDTH  saturating count of error cycles.
REQ-015 err_irq_o  out  1  registered; high whenever err_status_o != 0.

Function
REQ-016 ALIGN_BITS = log2(DATA_WIDTH/8); misaligned = valid and any addr[ALIGN_BITS-1:0] set.
REQ-017 Event bits: [0] AW misalign, [1] W wstrb all-zero while wvalid, [2] AR misalign, [3] AW stability, [4] W stability, [5] AR stability, [6] timeout on any of AW/W/AR.
REQ-018 Stability: a channel is pending when valid=1 and ready=0; addr, prot, data and strb of a pending channel are registered.
REQ-019 Stability event fires in the cycle after a pending cycle if valid=0, or any payload bit differs from the registered value.
REQ-020 Timeout: per-channel stall counter increments each pending cycle and clears on handshake (valid and ready) or valid=0.
REQ-021 Stall counter saturates at TIMEOUT_CYCLES; the timeout event fires once, in the cycle the counter reaches TIMEOUT_CYCLES.
REQ-022 err_awrite_o = bit0 or bit3 event; err_write_o = bit1 or bit4; err_read_o = bit2 or bit5; all same-cycle, no latency.
REQ-023 err_status_o: each bit sets one cycle after its event and holds until clr_i or reset.
REQ-024 err_count_o increments by 1 per cycle with any event (not per bit); it saturates at all-ones.
REQ-025 clr_i with a same-cycle event: the event wins; status takes that cycle's event bits and the count becomes 1.
REQ-026 err_irq_o is a registered copy of (next err_status_o != 0).
REQ-027 Simultaneous events on multiple channels set all corresponding bits in one cycle.
REQ-028 ERR_RESP_EN=0: all outputs are constant 0 and no state is instantiated.

Reset
REQ-029 rst_i high clears asynchronously: err_status_o=0, err_count_o=0, err_irq_o=0, stall counters=0, pending flags=0.
REQ-030 The first cycle after reset release never reports a stability event.
REQ-031 Reset asserted mid-stall discards the stall; a new timeout needs a full TIMEOUT_CYCLES after release.

Verification
REQ-032 DATA_WIDTH=32: awvalid=1, awaddr=0x1002, awready=1 for one cycle -> err_awrite_o=1 that cycle; next cycle err_status_o=0x01, err_count_o=1, err_irq_o=1.
REQ-033 Stability, data change: wvalid=1, wready=0, wdata=0xA5A5A5A5, then 0x5A5A5A5A next cycle -> err_write_o=1 in the second cycle; err_status_o bit4 set after.
REQ-034 Stability, valid drop: arvalid held 3 cycles with arready=0, then arvalid=0 -> err_read_o=1 in the drop cycle; bit5 set after.
REQ-035 TIMEOUT_CYCLES=4: awvalid=1, awready=0 for 10 cycles -> bit6 sets exactly once, 4 pending cycles in; err_count_o=1.
REQ-036 Clear collision: status=0x03, assert clr_i with a same-cycle AR misalign -> err_status_o=0x04, err_count_o=1.
REQ-037 Counter saturation: CNT_WIDTH=2, five error cycles -> err_count_o=3, stays 3.

Source files
------------

// File: rtl/axil_protocol_monitor.sv
// Passive AXI-Lite AW/W/AR checker: alignment, empty strobes, payload stability and stall timeouts.
// Per-channel error flags are same-cycle; sticky status, saturating count and irq are registered.
module axil_protocol_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter bit ERR_RESP_EN    = 1'b1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  input  logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  input  logic                    s_axi_wready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  input  logic                    s_axi_arready,
  input  logic                    clr_i,
  output logic                    err_awrite_o,
  output logic                    err_write_o,
  output logic                    err_read_o,
  output logic [6:0]              err_status_o,
  output logic [CNT_WIDTH-1:0]    err_count_o,
  output logic                    err_irq_o
);

  localparam int ALIGN_BITS = $clog2(DATA_WIDTH / 8);
  localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AP         = ADDR_WIDTH + 3;
  localparam int WP         = DATA_WIDTH + DATA_WIDTH / 8;

  generate
    if (ERR_RESP_EN) begin : g_mon
      logic [2:0]           vld;
      logic [2:0]           rdy;
      logic [2:0]           pend;
      logic [2:0]           pend_q;
      logic [2:0]           unstable;
      logic [2:0]           to_hit;
      logic [AP-1:0]        aw_pay;
      logic [AP-1:0]        aw_q;
      logic [AP-1:0]        ar_pay;
      logic [AP-1:0]        ar_q;
      logic [WP-1:0]        w_pay;
      logic [WP-1:0]        w_q;
      logic [TW-1:0]        stall [3];
      logic                 aw_mis;
      logic                 ar_mis;
      logic                 w_nostrb;
      logic [6:0]           ev;
      logic [6:0]           status_q;
      logic [6:0]           status_d;
      logic [CNT_WIDTH-1:0] count_q;
      logic [CNT_WIDTH-1:0] count_d;
      logic                 irq_q;

      assign vld    = {s_axi_arvalid, s_axi_wvalid, s_axi_awvalid};
      assign rdy    = {s_axi_arready, s_axi_wready, s_axi_awready};
      assign pend   = vld & ~rdy;
      assign aw_pay = {s_axi_awaddr, s_axi_awprot};
      assign ar_pay = {s_axi_araddr, s_axi_arprot};
      assign w_pay  = {s_axi_wdata, s_axi_wstrb};

      assign aw_mis   = s_axi_awvalid & (|s_axi_awaddr[ALIGN_BITS-1:0]);
      assign ar_mis   = s_axi_arvalid & (|s_axi_araddr[ALIGN_BITS-1:0]);
      assign w_nostrb = s_axi_wvalid & ~(|s_axi_wstrb);

      // pend_q is cleared by reset, so the first cycle after release cannot flag instability
      assign unstable[0] = pend_q[0] & (~vld[0] | (aw_pay != aw_q));
      assign unstable[1] = pend_q[1] & (~vld[1] | (w_pay  != w_q));
      assign unstable[2] = pend_q[2] & (~vld[2] | (ar_pay != ar_q));

      // Fires on the pending cycle that brings the counter to the limit; saturation keeps it single-shot
      always_comb begin
        to_hit = '0;
        for (int i = 0; i < 3; i++) begin
          to_hit[i] = pend[i] && (stall[i] == TW'(TIMEOUT_CYCLES - 1));
        end
      end

      assign ev = {|to_hit, unstable, ar_mis, w_nostrb, aw_mis};

      always_comb begin
        status_d = status_q | ev;
        count_d  = count_q;
        if (clr_i) begin
          status_d = ev;
          count_d  = CNT_WIDTH'(|ev);
        end else if ((|ev) && !(&count_q)) begin
          count_d = count_q + 1'b1;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pend_q   <= '0;
          aw_q     <= '0;
          w_q      <= '0;
          ar_q     <= '0;
          status_q <= '0;
          count_q  <= '0;
          irq_q    <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            stall[i] <= '0;
          end
        end else begin
          pend_q   <= pend;
          status_q <= status_d;
          count_q  <= count_d;
          irq_q    <= (status_d != 7'd0);
          if (pend[0]) aw_q <= aw_pay;
          if (pend[1]) w_q  <= w_pay;
          if (pend[2]) ar_q <= ar_pay;
          for (int i = 0; i < 3; i++) begin
            if (!pend[i]) begin
              stall[i] <= '0;
            end else if (stall[i] != TW'(TIMEOUT_CYCLES)) begin
              stall[i] <= stall[i] + 1'b1;
            end
          end
        end
      end

      assign err_awrite_o = ev[0] | ev[3];
      assign err_write_o  = ev[1] | ev[4];
      assign err_read_o   = ev[2] | ev[5];
      assign err_status_o = status_q;
      assign err_count_o  = count_q;
      assign err_irq_o    = irq_q;
    end else begin : g_off
      assign err_awrite_o = 1'b0;
      assign err_write_o  = 1'b0;
      assign err_read_o   = 1'b0;
      assign err_status_o = '0;
      assign err_count_o  = '0;
      assign err_irq_o    = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_axil_protocol_monitor.sv
// Directed protocol scenarios followed by random traffic, checked against a cycle-level reference model.
module tb_axil_protocol_monitor;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        wvalid = 1'b0;
  logic        wready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready = 1'b0;

  logic       d_aw, d_w, d_ar, d_irq;
  logic [6:0] d_status;
  logic [7:0] d_count;
  logic       s_aw, s_w, s_ar, s_irq;
  logic [6:0] s_status;
  logic [1:0] s_count;
  logic       o_aw, o_w, o_ar, o_irq;
  logic [6:0] o_status;
  logic [7:0] o_count;

  always #5 clk = ~clk;

  axil_protocol_monitor #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_RESP_EN(1'b1),
                          .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .clr_i(clr), .err_awrite_o(d_aw), .err_write_o(d_w), .err_read_o(d_ar),
    .err_status_o(d_status), .err_count_o(d_count), .err_irq_o(d_irq));

  axil_protocol_monitor #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_RESP_EN(1'b1),
                          .TIMEOUT_CYCLES(T), .CNT_WIDTH(2)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .clr_i(clr), .err_awrite_o(s_aw), .err_write_o(s_w), .err_read_o(s_ar),
    .err_status_o(s_status), .err_count_o(s_count), .err_irq_o(s_irq));

  axil_protocol_monitor #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_RESP_EN(1'b0),
                          .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) u_off (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .clr_i(clr), .err_awrite_o(o_aw), .err_write_o(o_w), .err_read_o(o_ar),
    .err_status_o(o_status), .err_count_o(o_count), .err_irq_o(o_irq));

  int checks = 0;
  int errors = 0;

  // Reference model: what the previous cycle looked like, and how long each channel has been stuck
  logic        p_aw, p_w, p_ar;
  logic [31:0] pa_addr, pr_addr, pw_data;
  logic [2:0]  pa_prot, pr_prot;
  logic [3:0]  pw_strb;
  int          run_aw, run_w, run_ar;
  logic [6:0]  m_status;
  int          m_count, m_count2;
  logic        m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p_aw = 0; p_w = 0; p_ar = 0;
    run_aw = 0; run_w = 0; run_ar = 0;
    m_status = '0; m_count = 0; m_count2 = 0; m_irq = 0;
  endtask

  function automatic logic [6:0] model_ev();
    logic [6:0] e;
    e[0] = awvalid && (awaddr % 4 != 0);
    e[1] = wvalid && (wstrb == 4'h0);
    e[2] = arvalid && (araddr % 4 != 0);
    e[3] = p_aw && (!awvalid || awaddr != pa_addr || awprot != pa_prot);
    e[4] = p_w  && (!wvalid  || wdata  != pw_data || wstrb  != pw_strb);
    e[5] = p_ar && (!arvalid || araddr != pr_addr || arprot != pr_prot);
    e[6] = (awvalid && !awready && run_aw + 1 == T) ||
           (wvalid  && !wready  && run_w  + 1 == T) ||
           (arvalid && !arready && run_ar + 1 == T);
    return e;
  endfunction

  task automatic cycle();
    logic [6:0] ev;
    @(negedge clk);
    ev = model_ev();
    chk("err_awrite", 32'(d_aw), 32'(ev[0] | ev[3]));
    chk("err_write",  32'(d_w),  32'(ev[1] | ev[4]));
    chk("err_read",   32'(d_ar), 32'(ev[2] | ev[5]));
    chk("status",     32'(d_status), 32'(m_status));
    chk("count",      32'(d_count),  32'(m_count));
    chk("irq",        32'(d_irq),    32'(m_irq));
    chk("sat_status", 32'(s_status), 32'(m_status));
    chk("sat_count",  32'(s_count),  32'(m_count2));
    chk("sat_flags",  32'({s_aw, s_w, s_ar, s_irq}), 32'({ev[0] | ev[3], ev[1] | ev[4], ev[2] | ev[5], m_irq}));
    chk("disabled",   32'({o_aw, o_w, o_ar, o_irq, o_status, o_count}), 32'd0);
    @(posedge clk);
    #1;
    if (clr) begin
      m_status = ev;
      m_count  = (ev != 0) ? 1 : 0;
      m_count2 = m_count;
    end else begin
      m_status = m_status | ev;
      if (ev != 0 && m_count < 255) m_count++;
      if (ev != 0 && m_count2 < 3) m_count2++;
    end
    m_irq = (m_status != 0);
    run_aw = (awvalid && !awready) ? run_aw + 1 : 0;
    run_w  = (wvalid  && !wready)  ? run_w  + 1 : 0;
    run_ar = (arvalid && !arready) ? run_ar + 1 : 0;
    p_aw = awvalid && !awready; pa_addr = awaddr; pa_prot = awprot;
    p_w  = wvalid  && !wready;  pw_data = wdata;  pw_strb = wstrb;
    p_ar = arvalid && !arready; pr_addr = araddr; pr_prot = arprot;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_async", 32'({d_status, d_count, d_irq, s_status, s_count, s_irq}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle();
    awvalid = 0; wvalid = 0; arvalid = 0;
    awready = 1; wready = 1; arready = 1;
    awaddr = 32'h100; araddr = 32'h200; wstrb = 4'hF; clr = 0;
  endtask

  task automatic clear_all();
    idle();
    clr = 1;
    cycle();
    clr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    model_reset();
    idle();
    #1;
    do_reset();
    cycle();
    cycle();

    // Misaligned AW handshake
    awvalid = 1; awaddr = 32'h1002; awready = 1;
    cycle();
    idle();
    chk("aw_mis_status", 32'(d_status), 32'h01);
    chk("aw_mis_count",  32'(d_count),  32'd1);
    chk("aw_mis_irq",    32'(d_irq),    32'd1);
    cycle();
    clear_all();
    chk("clr_status", 32'({d_status, d_count, d_irq}), 32'd0);

    // W data changes while stalled
    wvalid = 1; wready = 0; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    cycle();
    wdata = 32'h5A5A5A5A;
    cycle();
    chk("w_stab_bit4", 32'(d_status[4]), 32'd1);
    idle();
    cycle();
    clear_all();

    // AR valid dropped after three stalled cycles
    arvalid = 1; arready = 0; araddr = 32'h3000;
    repeat (3) cycle();
    arvalid = 0;
    cycle();
    chk("ar_drop_status", 32'(d_status), 32'h20);
    clear_all();

    // Long AW stall: one timeout only
    awvalid = 1; awready = 0; awaddr = 32'h4000;
    repeat (10) cycle();
    chk("timeout_status", 32'(d_status), 32'h40);
    chk("timeout_count",  32'(d_count),  32'd1);
    awvalid = 0; clr = 1;
    cycle();
    chk("drop_clr_status", 32'(d_status), 32'h08);
    chk("drop_clr_count",  32'(d_count),  32'd1);
    clear_all();

    // Clear colliding with an AR misalign
    awvalid = 1; awaddr = 32'h5001; wvalid = 1; wstrb = 4'h0;
    cycle();
    idle();
    chk("pre_clr_status", 32'(d_status), 32'h03);
    clr = 1; arvalid = 1; araddr = 32'h6003;
    cycle();
    idle();
    chk("clr_coll_status", 32'(d_status), 32'h04);
    chk("clr_coll_count",  32'(d_count),  32'd1);
    chk("clr_coll_irq",    32'(d_irq),    32'd1);
    clear_all();

    // Five error cycles against a 2-bit counter
    awvalid = 1; awaddr = 32'h7002;
    repeat (5) cycle();
    idle();
    chk("sat_count5", 32'(s_count), 32'd3);
    chk("wide_count5", 32'(d_count), 32'd5);
    cycle();
    chk("sat_hold", 32'(s_count), 32'd3);
    clear_all();

    // Reset in the middle of a stall discards the accumulated stall
    awvalid = 1; awready = 0; awaddr = 32'h8000;
    repeat (3) cycle();
    do_reset();
    repeat (3) cycle();
    chk("rst_stall_status", 32'(d_status), 32'h00);
    cycle();
    chk("rst_stall_timeout", 32'(d_status), 32'h40);
    idle();
    cycle();
    clear_all();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if (p_aw && $urandom_range(0, 9) != 0) begin
        awvalid = 1;
      end else begin
        r = $urandom;
        awvalid = ($urandom_range(0, 1) == 1);
        awaddr  = ($urandom_range(0, 5) == 0) ? r : (r & 32'hFFFF_FFFC);
        awprot  = 3'($urandom_range(0, 7));
      end
      if (p_w && $urandom_range(0, 9) != 0) begin
        wvalid = 1;
      end else begin
        wvalid = ($urandom_range(0, 1) == 1);
        wdata  = $urandom;
        wstrb  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (p_ar && $urandom_range(0, 9) != 0) begin
        arvalid = 1;
      end else begin
        r = $urandom;
        arvalid = ($urandom_range(0, 1) == 1);
        araddr  = ($urandom_range(0, 5) == 0) ? r : (r & 32'hFFFF_FFFC);
        arprot  = 3'($urandom_range(0, 7));
      end
      awready = ($urandom_range(0, 2) == 0);
      wready  = ($urandom_range(0, 2) == 0);
      arready = ($urandom_range(0, 2) == 0);
      clr     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle();
    end

    idle();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
